// File: rtl/pio_poll_master_pkg.sv
// Shared types, constants and helpers for the key PIO poller.
package pio_pkg;

    // Poll transaction phases
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } pio_state_e;

    // Word offset of the PIO DATA register
    localparam int unsigned PIO_DATA_OFFSET = 0;

    // Ceiling log2; 0 for values <= 1
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Width of a counter that must hold 0 .. n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/pio_poll_master_if.sv
// Avalon-MM read port toward the PIO plus the debounced key event stream.
interface pio_poll_master_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 2
) ();

    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [31:0]       avm_readdata;

    logic [DATA_W-1:0] key_state;
    logic              evt_valid;
    logic              evt_ready;
    logic [DATA_W-1:0] evt_press;
    logic [DATA_W-1:0] evt_release;
    logic              evt_overflow;

    // The poller: issues reads, produces key events
    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        output key_state,
        output evt_valid,
        input  evt_ready,
        output evt_press,
        output evt_release,
        output evt_overflow
    );

    // The environment: PIO responder and event consumer
    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        input  key_state,
        input  evt_valid,
        output evt_ready,
        input  evt_press,
        input  evt_release,
        input  evt_overflow
    );

endinterface

// File: rtl/pio_poll_master_debounce_lane.sv
// One-bit debouncer: the level flips only after DEBOUNCE_N consecutive
// captured samples that disagree with it.
module pio_debounce_lane
    import pio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic capture,
    input  logic sample,
    output logic state,
    output logic toggle_c
);

    localparam int unsigned        CNT_W    = cnt_width(DEBOUNCE_N);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_N - 1);

    logic [CNT_W-1:0] cnt;
    logic             differ_c;

    // Flip decision for the sample being captured this cycle
    always_comb begin
        differ_c = sample ^ state;
        toggle_c = capture & differ_c & (cnt == CNT_LAST);
    end

    // Run-length of disagreeing samples and the debounced level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            state <= 1'b0;
        end else if (capture) begin
            if (!differ_c) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                state <= ~state;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pio_poll_master.sv
// Periodically reads the key PIO DATA register over Avalon-MM, debounces
// every bit and publishes press/release masks on a valid/ready stream.
module pio_poll_master
    import pio_pkg::*;
#(
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned ADDR_W       = 2,
    parameter int unsigned POLL_DIV     = 50000,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned DEBOUNCE_N   = 4,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               clr_overflow,
    pio_poll_master_if.master  bus
);

    localparam int unsigned      POLL_W    = cnt_width(POLL_DIV);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_DIV - 1);
    localparam int unsigned      WAIT_W    = cnt_width(READ_LATENCY);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY - 1);

    pio_state_e        state;
    pio_state_e        state_n;
    logic [POLL_W-1:0] poll_cnt;
    logic [POLL_W-1:0] poll_cnt_n;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_n;
    logic              tick_c;
    logic              avm_read_q;

    logic              capture_c;
    logic [DATA_W-1:0] sample_c;
    logic [DATA_W-1:0] key_q;
    logic [DATA_W-1:0] toggle_c;
    logic [DATA_W-1:0] new_key_c;
    logic [DATA_W-1:0] press_c;
    logic [DATA_W-1:0] rel_c;
    logic              any_toggle_c;
    logic              merge_c;

    logic              evt_valid_q;
    logic [DATA_W-1:0] evt_press_q;
    logic [DATA_W-1:0] evt_rel_q;
    logic              evt_ovf_q;

    logic              unused_readdata;

    // Poll tick generation and the read transaction sequencer
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        poll_cnt_n = '0;
        tick_c     = 1'b0;

        if (enable) begin
            tick_c     = (poll_cnt == POLL_LAST);
            poll_cnt_n = tick_c ? '0 : poll_cnt + POLL_W'(1);
        end

        case (state)
            IDLE: begin
                if (tick_c) begin
                    state_n = READ;
                end
            end
            READ: begin
                wait_cnt_n = '0;
                state_n    = WAIT;
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_n = CAPTURE;
                end else begin
                    wait_cnt_n = wait_cnt + WAIT_W'(1);
                end
            end
            CAPTURE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Sequencer state; the read strobe is registered alongside the READ state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            poll_cnt   <= '0;
            wait_cnt   <= '0;
            avm_read_q <= 1'b0;
        end else begin
            state      <= state_n;
            poll_cnt   <= poll_cnt_n;
            wait_cnt   <= wait_cnt_n;
            avm_read_q <= (state_n == READ);
        end
    end

    // Normalise the sampled PIO bits so that 1 always means pressed
    always_comb begin
        capture_c = (state == CAPTURE);
        sample_c  = ACTIVE_LOW ? ~bus.avm_readdata[DATA_W-1:0]
                               :  bus.avm_readdata[DATA_W-1:0];
    end

    // Upper PIO data bits carry nothing of interest
    assign unused_readdata = ^bus.avm_readdata[31:DATA_W];

    for (genvar i = 0; i < DATA_W; i++) begin : g_lane
        pio_debounce_lane #(
            .DEBOUNCE_N (DEBOUNCE_N)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .capture  (capture_c),
            .sample   (sample_c[i]),
            .state    (key_q[i]),
            .toggle_c (toggle_c[i])
        );
    end

    // Masks for the level change about to land on key_state
    always_comb begin
        new_key_c    = key_q ^ toggle_c;
        press_c      = toggle_c & new_key_c;
        rel_c        = toggle_c & ~new_key_c;
        any_toggle_c = |toggle_c;
        merge_c      = any_toggle_c & evt_valid_q & ~bus.evt_ready;
    end

    // Event slot: load, merge into an unaccepted event, or retire on handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_valid_q <= 1'b0;
            evt_press_q <= '0;
            evt_rel_q   <= '0;
        end else if (any_toggle_c) begin
            evt_valid_q <= 1'b1;
            if (merge_c) begin
                evt_press_q <= evt_press_q | press_c;
                evt_rel_q   <= evt_rel_q | rel_c;
            end else begin
                evt_press_q <= press_c;
                evt_rel_q   <= rel_c;
            end
        end else if (evt_valid_q && bus.evt_ready) begin
            evt_valid_q <= 1'b0;
            evt_press_q <= '0;
            evt_rel_q   <= '0;
        end
    end

    // Sticky overflow; a merge in the same cycle beats the clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_ovf_q <= 1'b0;
        end else if (merge_c) begin
            evt_ovf_q <= 1'b1;
        end else if (clr_overflow) begin
            evt_ovf_q <= 1'b0;
        end
    end

    assign bus.avm_address  = ADDR_W'(PIO_DATA_OFFSET);
    assign bus.avm_read     = avm_read_q;
    assign bus.key_state    = key_q;
    assign bus.evt_valid    = evt_valid_q;
    assign bus.evt_press    = evt_press_q;
    assign bus.evt_release  = evt_rel_q;
    assign bus.evt_overflow = evt_ovf_q;

endmodule

// File: tb/tb_pio_poll_master.sv
// Directed bench for pio_poll_master: Avalon responder with registered
// readdata, a debounce/event reference model and an expectation queue.
module tb_pio_poll_master;

    logic        clk          = 1'b0;
    logic        rst          = 1'b1;
    logic        enable       = 1'b1;
    logic        clr_overflow = 1'b0;
    logic        evt_ready    = 1'b0;
    logic [3:0]  raw          = 4'hF;
    logic [31:0] rdata_q      = 32'h0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rd_cyc = 0;

    typedef struct packed {
        logic [3:0] key;
        logic       valid;
        logic [3:0] press;
        logic [3:0] rel;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    logic [3:0] m_key;
    logic [3:0] m_press;
    logic [3:0] m_rel;
    logic       m_valid;
    logic       m_ovf;
    int         m_cnt[4];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pio_poll_master_if #(.DATA_W(4), .ADDR_W(2)) bus ();

    pio_poll_master #(
        .DATA_W       (4),
        .ADDR_W       (2),
        .POLL_DIV     (8),
        .READ_LATENCY (1),
        .DEBOUNCE_N   (3),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .enable       (enable),
        .clr_overflow (clr_overflow),
        .bus          (bus)
    );

    // Responder: readdata registered one cycle after the read strobe
    always @(posedge clk) begin
        if (bus.avm_read) rdata_q <= {28'hA5A5A5A, raw};
    end

    assign bus.avm_readdata = rdata_q;
    assign bus.evt_ready    = evt_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_key = '0; m_press = '0; m_rel = '0; m_valid = 1'b0; m_ovf = 1'b0;
        for (int b = 0; b < 4; b++) m_cnt[b] = 0;
        sb.delete();
    endtask

    // Reference for one CAPTURE with DEBOUNCE_N=3 and active-low keys
    task automatic model_capture(input logic [3:0] raw_v, input logic ready_v);
        logic [3:0] pressed;
        logic [3:0] tog;
        logic [3:0] nk;
        pressed = ~raw_v;
        tog     = '0;
        for (int b = 0; b < 4; b++) begin
            if (pressed[b] == m_key[b]) m_cnt[b] = 0;
            else if (m_cnt[b] == 2) begin tog[b] = 1'b1; m_cnt[b] = 0; end
            else m_cnt[b] = m_cnt[b] + 1;
        end
        nk = m_key ^ tog;
        if (tog != 4'h0) begin
            if (!m_valid || ready_v) begin
                m_press = tog & nk;
                m_rel   = tog & ~nk;
            end else begin
                m_press = m_press | (tog & nk);
                m_rel   = m_rel | (tog & ~nk);
                m_ovf   = 1'b1;
            end
            m_valid = 1'b1;
        end
        m_key = nk;
        sb.push_back('{key: m_key, valid: m_valid, press: m_press, rel: m_rel, ovf: m_ovf});
    endtask

    // Advance to the negedge inside the next READ cycle, bounded
    task automatic next_read(output int n, output bit found);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (bus.avm_read === 1'b1) break;
        end
        found = (bus.avm_read === 1'b1);
        if (!found) chk("read_timeout", 32'd0, 32'd1);
        else rd_cyc = cyc;
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_key"},   32'(bus.key_state),    32'(e.key));
        chk({tag, "_valid"}, 32'(bus.evt_valid),    32'(e.valid));
        chk({tag, "_press"}, 32'(bus.evt_press),    32'(e.press));
        chk({tag, "_rel"},   32'(bus.evt_release),  32'(e.rel));
        chk({tag, "_ovf"},   32'(bus.evt_overflow), 32'(e.ovf));
    endtask

    // One poll: drive raw, expect model result the cycle after CAPTURE
    task automatic do_poll(input string tag, input logic [3:0] raw_v,
                           input logic ready_v, input bit drop_en);
        int n;
        bit found;
        raw       = raw_v;
        evt_ready = ready_v;
        model_capture(raw_v, ready_v);
        next_read(n, found);
        if (!found) begin
            void'(sb.pop_back());
            return;
        end
        chk({tag, "_addr"}, 32'(bus.avm_address), 32'd0);
        if (drop_en) enable = 1'b0;
        repeat (3) @(negedge clk);
        check_pop(tag);
        if (ready_v) begin
            @(negedge clk);
            chk({tag, "_drained"}, 32'(bus.evt_valid), 32'd0);
            m_valid = 1'b0; m_press = '0; m_rel = '0;
        end
    endtask

    initial begin
        int n;
        int prev;
        bit found;
        int reads;

        model_reset();

        // Reset state
        @(negedge clk);
        chk("rst_read",  32'(bus.avm_read),     32'd0);
        chk("rst_addr",  32'(bus.avm_address),  32'd0);
        chk("rst_key",   32'(bus.key_state),    32'd0);
        chk("rst_valid", 32'(bus.evt_valid),    32'd0);
        chk("rst_ovf",   32'(bus.evt_overflow), 32'd0);

        // 1: idle keys, reads every 8 cycles
        rst = 1'b0;
        next_read(n, found);
        chk("t1_first_read", 32'(n), 32'd8);
        chk("t1_pulse_addr", 32'(bus.avm_address), 32'd0);
        @(negedge clk);
        chk("t1_strobe_len", 32'(bus.avm_read), 32'd0);
        repeat (2) @(negedge clk);
        chk("t1_key0",   32'(bus.key_state), 32'd0);
        chk("t1_valid0", 32'(bus.evt_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            prev = rd_cyc;
            do_poll("t1_idle", 4'hF, 1'b0, 1'b0);
            chk("t1_period", 32'(rd_cyc - prev), 32'd8);
        end

        // 2: KEY0 press then release, consumer always ready
        for (int i = 0; i < 3; i++) do_poll("t2_press", 4'hE, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) do_poll("t2_rel", 4'hF, 1'b1, 1'b0);

        // 3: bouncing KEY0 never settles
        do_poll("t3_b0", 4'hE, 1'b1, 1'b0);
        do_poll("t3_b1", 4'hF, 1'b1, 1'b0);
        do_poll("t3_b2", 4'hE, 1'b1, 1'b0);
        do_poll("t3_b3", 4'hE, 1'b1, 1'b0);
        do_poll("t3_b4", 4'hF, 1'b1, 1'b0);

        // 4: stalled consumer, second press merges and flags overflow
        for (int i = 0; i < 3; i++) do_poll("t4_k0", 4'hE, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) do_poll("t4_k1", 4'hC, 1'b0, 1'b0);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        m_ovf = 1'b0;
        chk("t4_ovf_clr",   32'(bus.evt_overflow), 32'(m_ovf));
        chk("t4_held_press", 32'(bus.evt_press), 32'h3);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        m_valid = 1'b0; m_press = '0; m_rel = '0;
        chk("t4_drain_valid", 32'(bus.evt_valid), 32'd0);
        chk("t4_drain_press", 32'(bus.evt_press), 32'd0);
        for (int i = 0; i < 3; i++) do_poll("t4_rel", 4'hF, 1'b1, 1'b0);

        // 5: asynchronous reset in the middle of a read
        for (int i = 0; i < 3; i++) do_poll("t5_setup", 4'hE, 1'b0, 1'b0);
        raw = 4'hE;
        next_read(n, found);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_rst_key",   32'(bus.key_state),   32'd0);
        chk("t5_rst_valid", 32'(bus.evt_valid),   32'd0);
        chk("t5_rst_press", 32'(bus.evt_press),   32'd0);
        chk("t5_rst_read",  32'(bus.avm_read),    32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        raw = 4'hF;
        next_read(n, found);
        chk("t5_first_read", 32'(n), 32'd8);
        repeat (3) @(negedge clk);
        chk("t5_key_after", 32'(bus.key_state), 32'd0);
        chk("t5_valid_after", 32'(bus.evt_valid), 32'd0);

        // 6: enable dropped after READ, capture still completes
        do_poll("t6_p0", 4'hE, 1'b1, 1'b0);
        do_poll("t6_p1", 4'hE, 1'b1, 1'b0);
        do_poll("t6_drop", 4'hE, 1'b1, 1'b1);
        reads = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.avm_read === 1'b1) reads++;
        end
        chk("t6_no_reads", 32'(reads), 32'd0);
        enable = 1'b1;
        next_read(n, found);
        chk("t6_resume", 32'(n), 32'd8);
        repeat (3) @(negedge clk);
        chk("t6_key_hold", 32'(bus.key_state), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
